exec_step_ctrl: RTL and testbench

//  Run/halt/single-step sequencer for the core. Sits between the debug interface and the

---
 rtl/exec_step_ctrl.sv | 85 ++++++++
 tb/tb_exec_step_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/exec_step_ctrl.sv
// exec_step_ctrl: run/halt/single-step sequencer gating core progress via core_run
module exec_step_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int CNT_W     = 16,
  parameter int START_RUN = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              core_pc_en,
  input  logic              core_cycle,
  input  logic              core_hlt,
  input  logic              cnt_clr,
  output logic              core_run,
  output logic              halted,
  output logic [2:0]        halt_cause,
  output logic              step_done,
  output logic [CNT_W-1:0]  retire_cnt
);
  typedef enum logic [1:0] {HALT, RUN, STEP, DRAIN} state_t;
  state_t state, state_nx;
  logic [2:0] cause_nx;
  logic bdry, bp_skip, bp_hit, retire;
  assign bdry   = ~core_cycle;
  assign bp_hit = bp_en && pc == bp_addr && bdry && !bp_skip && state == RUN;
  assign retire = core_run & core_pc_en;
  always_comb begin
    state_nx = state;
    cause_nx = halt_cause;
    core_run = 1'b0;
    case (state)
      HALT: state_nx = step_req ? STEP : run_req ? RUN : HALT;
      RUN:
        if (bp_hit) begin
          state_nx = HALT;
          cause_nx = 3'd3;
        end else if (core_hlt && bdry) begin
          state_nx = HALT;
          cause_nx = 3'd4;
        end else if (halt_req && bdry) begin
          state_nx = HALT;
          cause_nx = 3'd1;
        end else begin
          core_run = 1'b1;
          state_nx = halt_req ? DRAIN : RUN;
        end
      STEP:
        if (core_hlt && bdry) begin
          state_nx = HALT;
          cause_nx = 3'd4;
        end else begin
          core_run = 1'b1;
          state_nx = core_pc_en ? HALT : STEP;
          cause_nx = core_pc_en ? 3'd2 : halt_cause;
        end
      default: begin
        core_run = 1'b1;
        state_nx = core_pc_en ? HALT : DRAIN;
        cause_nx = core_pc_en ? 3'd1 : halt_cause;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= (START_RUN != 0) ? RUN : HALT;
      halted     <= (START_RUN == 0);
      halt_cause <= 3'd0;
      step_done  <= 1'b0;
      retire_cnt <= '0;
      bp_skip    <= 1'b1;
    end else begin
      state      <= state_nx;
      halted     <= state_nx == HALT;
      halt_cause <= cause_nx;
      step_done  <= state == STEP && retire;
      retire_cnt <= cnt_clr ? '0 : retire_cnt + CNT_W'(retire);
      bp_skip    <= (state == HALT && state_nx != HALT) ? 1'b1 : retire ? 1'b0 : bp_skip;
    end
  end
endmodule

// File: tb/tb_exec_step_ctrl.sv
// tb_exec_step_ctrl: directed self-checking bench for exec_step_ctrl
module tb_exec_step_ctrl;
  logic clock = 0, reset = 1;
  logic run_req = 0, halt_req = 0, step_req = 0, bp_en = 0;
  logic [7:0] bp_addr = 8'h10, pc = 8'h00;
  logic core_pc_en = 0, core_cycle = 0, core_hlt = 0, cnt_clr = 0;
  logic core_run, halted, step_done;
  logic [2:0] halt_cause;
  logic [3:0] retire_cnt;
  int checks = 0, failures = 0;
  exec_step_ctrl #(.ADDR_W(8), .CNT_W(4), .START_RUN(0)) dut (
    .clock(clock), .reset(reset), .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .core_pc_en(core_pc_en), .core_cycle(core_cycle), .core_hlt(core_hlt),
    .cnt_clr(cnt_clr), .core_run(core_run), .halted(halted),
    .halt_cause(halt_cause), .step_done(step_done), .retire_cnt(retire_cnt)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  initial begin
    tick; tick;
    reset = 0;
    tick; tick; tick;
    check("rst_halted", 32'(halted), 1);
    check("rst_cause", 32'(halt_cause), 0);
    check("rst_run", 32'(core_run), 0);
    check("rst_cnt", 32'(retire_cnt), 0);
    check("rst_sdone", 32'(step_done), 0);
    step_req = 1; core_pc_en = 1;
    tick;
    step_req = 0; #1;
    check("add_run", 32'(core_run), 1);
    check("add_halted0", 32'(halted), 0);
    tick;
    check("add_cnt", 32'(retire_cnt), 1);
    check("add_sdone", 32'(step_done), 1);
    check("add_cause", 32'(halt_cause), 2);
    check("add_halted", 32'(halted), 1);
    check("add_run_off", 32'(core_run), 0);
    tick;
    check("add_sdone_end", 32'(step_done), 0);
    check("add_cnt_hold", 32'(retire_cnt), 1);
    core_pc_en = 0; step_req = 1;
    tick;
    step_req = 0; #1;
    check("mul_run_c0", 32'(core_run), 1);
    tick;
    core_cycle = 1; core_pc_en = 1; #1;
    check("mul_cnt_mid", 32'(retire_cnt), 1);
    check("mul_run_c1", 32'(core_run), 1);
    tick;
    core_cycle = 0; core_pc_en = 0; #1;
    check("mul_cnt", 32'(retire_cnt), 2);
    check("mul_sdone", 32'(step_done), 1);
    check("mul_run_off", 32'(core_run), 0);
    bp_en = 1; pc = 8'h0e; core_pc_en = 1; run_req = 1;
    tick;
    run_req = 0;
    tick;
    pc = 8'h0f;
    tick;
    pc = 8'h10; #1;
    check("bp_cnt_before", 32'(retire_cnt), 4);
    check("bp_run_mask", 32'(core_run), 0);
    tick;
    check("bp_halted", 32'(halted), 1);
    check("bp_cause", 32'(halt_cause), 3);
    check("bp_cnt_hold", 32'(retire_cnt), 4);
    run_req = 1;
    tick;
    run_req = 0; #1;
    check("bp_resume_run", 32'(core_run), 1);
    tick;
    check("bp_resume_cnt", 32'(retire_cnt), 5);
    pc = 8'h11; core_pc_en = 0; #1;
    check("lda_c0_run", 32'(core_run), 1);
    tick;
    core_cycle = 1; core_pc_en = 1; halt_req = 1; #1;
    check("lda_c1_run", 32'(core_run), 1);
    tick;
    halt_req = 0; pc = 8'h12; core_cycle = 0; #1;
    check("drain_halted", 32'(halted), 0);
    check("drain_run", 32'(core_run), 1);
    check("drain_cnt", 32'(retire_cnt), 6);
    tick;
    check("drain_done_halted", 32'(halted), 1);
    check("drain_cause", 32'(halt_cause), 1);
    check("drain_cnt_end", 32'(retire_cnt), 7);
    core_pc_en = 0; run_req = 1;
    tick;
    run_req = 0; pc = 8'h13; core_hlt = 1; #1;
    check("hlt_run_mask", 32'(core_run), 0);
    tick;
    core_hlt = 0;
    check("hlt_halted", 32'(halted), 1);
    check("hlt_cause", 32'(halt_cause), 4);
    check("hlt_cnt", 32'(retire_cnt), 7);
    step_req = 1;
    tick;
    step_req = 0; core_pc_en = 1; cnt_clr = 1;
    tick;
    cnt_clr = 0; core_pc_en = 0;
    check("clr_cnt", 32'(retire_cnt), 0);
    check("clr_sdone", 32'(step_done), 1);
    bp_en = 0; run_req = 1;
    tick;
    run_req = 0; core_pc_en = 1;
    for (int i = 0; i < 15; i++) begin
      pc = 8'(8'h20 + i);
      tick;
    end
    check("wrap_15", 32'(retire_cnt), 15);
    tick;
    check("wrap_0", 32'(retire_cnt), 0);
    halt_req = 1; #1;
    check("bhalt_run_mask", 32'(core_run), 0);
    tick;
    halt_req = 0; core_pc_en = 0;
    check("bhalt_cause", 32'(halt_cause), 1);
    check("bhalt_cnt", 32'(retire_cnt), 0);
    step_req = 1;
    tick;
    step_req = 0; #1;
    check("astep_run", 32'(core_run), 1);
    #2 reset = 1;
    #1;
    check("arst_run", 32'(core_run), 0);
    check("arst_halted", 32'(halted), 1);
    check("arst_cause", 32'(halt_cause), 0);
    tick;
    reset = 0;
    tick; tick;
    check("arst_stay_run", 32'(core_run), 0);
    check("arst_stay_halted", 32'(halted), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
